imem_port_arbiter: RTL and testbench
====================================

// Module: imem_port_arbiter
// PURPOSE
//  Shares the single-port, byte-wide instruction memory between two requesters.
//  Requester F is the fetch stage: reads one little-endian instruction word.
//  Requester L is the program loader: writes one little-endian word.
//  Each word is sequenced as WIDTH/8 byte beats on the memory port; ties are
//  resolved by alternating priority.
// PARAMETERS
//  WIDTH  32  word width in bits; multiple of 8; BEATS = WIDTH/8
//  AW     16  byte-address width (memory depth 2**AW bytes)
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  f_req      in   1      fetch request; addr held stable until accepted
//  f_addr     in   AW     fetch byte address (unaligned allowed)
//  f_ready    out  1      fetch accepted on an edge where f_req & f_ready
//  f_valid    out  1      one-cycle pulse: f_instr holds the fetched word
//  f_instr    out  WIDTH  assembled word; byte k read from f_addr+k
//  l_req      in   1      loader request; addr/data held until accepted
//  l_addr     in   AW     loader byte address
//  l_wdata    in   WIDTH  word to write; byte k = l_wdata[8k+7:8k]
//  l_ready    out  1      loader accepted on an edge where l_req & l_ready
//  l_done     out  1      one-cycle pulse after the last byte write
//  busy       out  1      high whenever state != IDLE
//  mem_addr   out  AW     memory byte address
//  mem_we     out  1      memory write strobe
//  mem_wdata  out  8      memory write byte
//  mem_rdata  in   8      read byte; synchronous, valid 1 cycle after mem_addr
// BEHAVIOUR
//  States: IDLE, FRD (BEATS cycles), FWAIT (1 cycle), LWR (BEATS cycles).
//  Beat counter cnt: 0..BEATS-1; cleared on every accept.
//  last_gnt register: F or L; reset value L (fetch wins the first tie).
//  Ready signals (combinational; depend only on state, l_req, f_req, last_gnt):
//   - f_ready = IDLE & ~(l_req & last_gnt==F)
//   - l_ready = IDLE & ~(f_req & last_gnt==L)
//   - Both requesting in IDLE: exactly one ready; the side not granted last.
//  Accept: latch the address (and l_wdata), set last_gnt, cnt=0.
//   - Fetch accept -> FRD; loader accept -> LWR.
//  FRD: mem_addr = base+cnt, mem_we = 0.
//   - Byte captured on the edge after each beat into f_instr[8j+7:8j].
//   - After cnt==BEATS-1 -> FWAIT; FWAIT captures the final byte.
//   - FWAIT -> IDLE, registering f_valid=1 for exactly one cycle.
//   - Latency: accept edge E0 -> f_valid high in cycle after edge E(BEATS+1).
//   - f_instr holds its value until the next fetch overwrites it.
//  LWR: mem_addr = base+cnt, mem_we = 1, mem_wdata = byte cnt of the latched word.
//   - After cnt==BEATS-1 -> IDLE, registering l_done=1 for one cycle.
//  IDLE/FWAIT: mem_we = 0; mem_addr and mem_wdata hold their last values.
//  Address arithmetic is modulo 2**AW; bursts wrap past top of memory.
//  No preemption: requests arriving mid-burst wait; ready stays 0 while busy.
//  Back-to-back: a new accept is legal in the IDLE cycle that shows f_valid or l_done.
//  Reset (async, any state): state=IDLE, cnt=0, last_gnt=L.
//   - f_valid, l_done, f_instr, mem_addr, mem_we, mem_wdata all cleared to 0.
//   - A partially written word stays partially written in memory.
// TESTING
//  1 Reset in LWR beat 2 -> next cycle busy=0, mem_we=0, f_instr=0; bytes 0..1 kept.
//  2 Mem[0x10..0x13]=13,00,50,93; fetch 0x0010 -> f_instr=0x93500013; f_valid at E5.
//  3 Load 0xDEADBEEF @0x0100 -> 0x0100..0x0103 = EF,BE,AD,DE; l_done 1 cycle.
//  4 f_req and l_req both set from reset:
//     - order F, L, F, L; four grants, no starvation.
//  5 Fetch @0xFFFE -> addresses FFFE,FFFF,0000,0001 in order; word assembled.
//  6 l_req mid-FRD -> l_ready=0 until IDLE; no mem_we during FRD/FWAIT.
//     Then L granted (last_gnt=F).

Source files
------------

// File: rtl/imem_port_arbiter.sv
// ---------------------------------------------------------------------------
// imem_port_arbiter
//
// Shares one single-port, byte-wide instruction memory between the fetch
// stage (F, reads one little-endian word) and the program loader (L, writes
// one little-endian word). Every word is moved as BEATS = WIDTH/8 byte beats.
// When both sides ask at once, the side that was not granted last wins.
// Once a burst has started it always runs to completion.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   f_req, f_addr         fetch request and byte address
//   f_ready               fetch accepted on an edge with f_req & f_ready
//   f_valid, f_instr      one-cycle pulse with the assembled fetched word
//   l_req, l_addr,        loader request, byte address and word to write
//   l_wdata
//   l_ready               loader accepted on an edge with l_req & l_ready
//   l_done                one-cycle pulse after the last byte write
//   busy                  high whenever a burst is in progress
//   mem_addr, mem_we,     registered byte-wide memory port
//   mem_wdata
//   mem_rdata             read byte, valid one cycle after mem_addr
// ---------------------------------------------------------------------------
module imem_port_arbiter #(
    parameter int WIDTH = 32,
    parameter int AW    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             f_req,
    input  logic [AW-1:0]    f_addr,
    output logic             f_ready,
    output logic             f_valid,
    output logic [WIDTH-1:0] f_instr,
    input  logic             l_req,
    input  logic [AW-1:0]    l_addr,
    input  logic [WIDTH-1:0] l_wdata,
    output logic             l_ready,
    output logic             l_done,
    output logic             busy,
    output logic [AW-1:0]    mem_addr,
    output logic             mem_we,
    output logic [7:0]       mem_wdata,
    input  logic [7:0]       mem_rdata
);

    localparam int BEATS = WIDTH / 8;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRD   = 2'd1,
        FWAIT = 2'd2,
        LWR   = 2'd3
    } state_e;

    typedef enum logic {
        GNT_F = 1'b0,
        GNT_L = 1'b1
    } gnt_e;

    state_e           state_q;
    gnt_e             lastGnt_q;
    logic [CW-1:0]    cnt_q;
    logic [AW-1:0]    base_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] fInstr_q;
    logic             fValid_q;
    logic             lDone_q;
    logic [AW-1:0]    memAddr_q;
    logic             memWe_q;
    logic [7:0]       memWdata_q;

    logic             isIdle;
    logic             fAccept;
    logic             lAccept;
    logic             lastBeat;
    logic [CW-1:0]    cntInc;
    logic [CW-1:0]    cntPrev;

    // Grant decision: only one side can be ready when both are asking, and it
    // is always the side that did not win the previous grant.
    assign isIdle   = (state_q == IDLE);
    assign f_ready  = isIdle & ~(l_req & (lastGnt_q == GNT_F));
    assign l_ready  = isIdle & ~(f_req & (lastGnt_q == GNT_L));
    assign fAccept  = f_req & f_ready;
    assign lAccept  = l_req & l_ready;

    assign lastBeat = (cnt_q == CW'(BEATS - 1));
    assign cntInc   = cnt_q + CW'(1);
    assign cntPrev  = cnt_q - CW'(1);

    // Burst sequencer. The memory port is registered, so the address for
    // beat k is loaded on the edge that enters beat k. Read data trails the
    // address by one cycle, which is why the byte of beat k-1 is captured
    // during beat k and the final byte needs the extra FWAIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lastGnt_q  <= GNT_L;
            cnt_q      <= '0;
            base_q     <= '0;
            wdata_q    <= '0;
            fInstr_q   <= '0;
            fValid_q   <= 1'b0;
            lDone_q    <= 1'b0;
            memAddr_q  <= '0;
            memWe_q    <= 1'b0;
            memWdata_q <= '0;
        end else begin
            fValid_q <= 1'b0;
            lDone_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fAccept) begin
                        state_q   <= FRD;
                        lastGnt_q <= GNT_F;
                        cnt_q     <= '0;
                        base_q    <= f_addr;
                        memAddr_q <= f_addr;
                        memWe_q   <= 1'b0;
                    end else if (lAccept) begin
                        state_q    <= LWR;
                        lastGnt_q  <= GNT_L;
                        cnt_q      <= '0;
                        base_q     <= l_addr;
                        wdata_q    <= l_wdata;
                        memAddr_q  <= l_addr;
                        memWe_q    <= 1'b1;
                        memWdata_q <= l_wdata[7:0];
                    end
                end
                FRD: begin
                    // Beat 0 has no returned byte yet; rdata is stale then.
                    if (cnt_q != '0) begin
                        fInstr_q[{cntPrev, 3'b000} +: 8] <= mem_rdata;
                    end
                    if (lastBeat) begin
                        state_q <= FWAIT;
                    end else begin
                        cnt_q     <= cntInc;
                        memAddr_q <= base_q + AW'(cntInc);
                    end
                end
                FWAIT: begin
                    fInstr_q[WIDTH-8 +: 8] <= mem_rdata;
                    fValid_q               <= 1'b1;
                    state_q                <= IDLE;
                end
                LWR: begin
                    if (lastBeat) begin
                        memWe_q <= 1'b0;
                        lDone_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q      <= cntInc;
                        memAddr_q  <= base_q + AW'(cntInc);
                        memWdata_q <= wdata_q[{cntInc, 3'b000} +: 8];
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = ~isIdle;
    assign f_valid   = fValid_q;
    assign f_instr   = fInstr_q;
    assign l_done    = lDone_q;
    assign mem_addr  = memAddr_q;
    assign mem_we    = memWe_q;
    assign mem_wdata = memWdata_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imem_port_arbiter
//
// Bench for imem_port_arbiter with a 64 KiB synchronous byte memory model.
// Expected fetched words and expected memory writes go into queues as the
// requests are driven; a negedge monitor pops them when the DUT raises
// f_valid or mem_we. A table of fetch/load vectors covers the main function,
// followed by hand-written sequences for arbitration, blocking while busy and
// reset in the middle of a write burst.
// ---------------------------------------------------------------------------
module tb_imem_port_arbiter;

    localparam int WIDTH = 32;
    localparam int AW    = 16;
    localparam int BEATS = WIDTH / 8;

    logic             clk;
    logic             rst_n;
    logic             f_req;
    logic [AW-1:0]    f_addr;
    logic             f_ready;
    logic             f_valid;
    logic [WIDTH-1:0] f_instr;
    logic             l_req;
    logic [AW-1:0]    l_addr;
    logic [WIDTH-1:0] l_wdata;
    logic             l_ready;
    logic             l_done;
    logic             busy;
    logic [AW-1:0]    mem_addr;
    logic             mem_we;
    logic [7:0]       mem_wdata;
    logic [7:0]       mem_rdata;

    logic [7:0]       mem [0:65535];

    logic [31:0]      expQ[$];
    logic [23:0]      writeQ[$];

    int               nCompared;
    int               nMismatched;

    typedef struct {
        bit          isLoad;
        logic [15:0] addr;
        logic [31:0] data;
    } vec_t;

    vec_t vecs [8];

    imem_port_arbiter #(
        .WIDTH(WIDTH),
        .AW   (AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .f_req    (f_req),
        .f_addr   (f_addr),
        .f_ready  (f_ready),
        .f_valid  (f_valid),
        .f_instr  (f_instr),
        .l_req    (l_req),
        .l_addr   (l_addr),
        .l_wdata  (l_wdata),
        .l_ready  (l_ready),
        .l_done   (l_done),
        .busy     (busy),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // 100 MHz-style free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous byte memory: write on the edge, read data appears one
    // cycle after the address.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every f_valid must match the oldest expected word,
    // every mem_we beat must match the oldest expected address/byte pair.
    always @(negedge clk) begin : scoreboard
        logic [31:0] expWord;
        logic [23:0] expWrite;
        if (rst_n) begin
            if (f_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected f_valid", 32'd1, 32'd0);
                end else begin
                    expWord = expQ.pop_front();
                    checkOutput("f_instr", f_instr, expWord);
                end
            end
            if (mem_we) begin
                if (writeQ.size() == 0) begin
                    checkOutput("unexpected mem_we", 32'd1, 32'd0);
                end else begin
                    expWrite = writeQ.pop_front();
                    checkOutput("mem write", 32'({mem_addr, mem_wdata}), 32'(expWrite));
                end
            end
        end
    end

    task automatic pushWrites(input logic [15:0] addr, input logic [31:0] data);
        for (int k = 0; k < BEATS; k++) begin
            writeQ.push_back({addr + 16'(k), data[8*k +: 8]});
        end
    endtask

    // Fetch one word and check address sequence, latency and pulse width.
    task automatic runFetch(input logic [15:0] addr, input logic [31:0] expWord);
        int cycles;
        int waits;
        logic [15:0] expA;
        expQ.push_back(expWord);
        @(negedge clk);
        f_req  = 1'b1;
        f_addr = addr;
        #1;
        waits = 0;
        while (!f_ready && waits < 40) begin
            @(negedge clk);
            #1;
            waits++;
        end
        checkOutput("fetch accept", 32'(f_ready), 32'd1);
        @(posedge clk);
        #1;
        f_req  = 1'b0;
        cycles = 0;
        while (cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (cycles <= BEATS) begin
                expA = addr + 16'(cycles - 1);
                checkOutput("fetch mem_addr", 32'(mem_addr), 32'(expA));
                checkOutput("fetch mem_we", 32'(mem_we), 32'd0);
            end
            if (f_valid) break;
        end
        checkOutput("fetch latency", 32'(cycles), 32'(BEATS + 2));
        @(negedge clk);
        checkOutput("f_valid pulse", 32'(f_valid), 32'd0);
    endtask

    // Load one word; the scoreboard checks every byte write.
    task automatic runLoad(input logic [15:0] addr, input logic [31:0] data);
        int cycles;
        int waits;
        pushWrites(addr, data);
        @(negedge clk);
        l_req   = 1'b1;
        l_addr  = addr;
        l_wdata = data;
        #1;
        waits = 0;
        while (!l_ready && waits < 40) begin
            @(negedge clk);
            #1;
            waits++;
        end
        checkOutput("load accept", 32'(l_ready), 32'd1);
        @(posedge clk);
        #1;
        l_req  = 1'b0;
        cycles = 0;
        while (cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (cycles <= BEATS) checkOutput("load busy", 32'(busy), 32'd1);
            if (l_done) break;
        end
        checkOutput("l_done latency", 32'(cycles), 32'(BEATS + 1));
        @(negedge clk);
        checkOutput("l_done pulse", 32'(l_done), 32'd0);
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.isLoad) runLoad(v.addr, v.data);
        else          runFetch(v.addr, v.data);
    endtask

    initial begin
        int  cycles;
        int  waits;
        bit  done;
        bit  gotGrant;
        bit  gotL;
        logic expOrder [4];

        nCompared   = 0;
        nMismatched = 0;
        rst_n   = 1'b0;
        f_req   = 1'b0;
        f_addr  = '0;
        l_req   = 1'b0;
        l_addr  = '0;
        l_wdata = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0010] = 8'h13;
        mem[16'h0011] = 8'h00;
        mem[16'h0012] = 8'h50;
        mem[16'h0013] = 8'h93;
        mem[16'h0014] = 8'h6F;

        // Vector table: fetches carry the expected word, loads the word to write.
        vecs[0] = '{1'b0, 16'h0010, 32'h93500013};
        vecs[1] = '{1'b1, 16'h0100, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 16'h0100, 32'hDEADBEEF};
        vecs[3] = '{1'b0, 16'h0011, 32'h6F935000};
        vecs[4] = '{1'b1, 16'hFFFE, 32'h11223344};
        vecs[5] = '{1'b0, 16'hFFFE, 32'h11223344};
        vecs[6] = '{1'b1, 16'h0200, 32'hC3A55A3C};
        vecs[7] = '{1'b0, 16'h0201, 32'h00C3A55A};

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset f_valid", 32'(f_valid), 32'd0);
        checkOutput("reset l_done", 32'(l_done), 32'd0);
        checkOutput("reset f_instr", f_instr, 32'd0);
        checkOutput("reset mem_we", 32'(mem_we), 32'd0);
        checkOutput("reset mem_addr", 32'(mem_addr), 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("idle f_ready", 32'(f_ready), 32'd1);
        checkOutput("idle l_ready", 32'(l_ready), 32'd1);

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

        checkOutput("load bytes 0x0100",
                    32'({mem[16'h0103], mem[16'h0102], mem[16'h0101], mem[16'h0100]}),
                    32'hDEADBEEF);
        checkOutput("wrap bytes",
                    32'({mem[16'h0001], mem[16'h0000], mem[16'hFFFF], mem[16'hFFFE]}),
                    32'h11223344);

        // Loader request arrives mid-fetch: must wait, then win the next grant.
        expQ.push_back(32'h93500013);
        @(negedge clk);
        f_req  = 1'b1;
        f_addr = 16'h0010;
        #1;
        checkOutput("blk f_ready", 32'(f_ready), 32'd1);
        @(posedge clk);
        #1;
        f_req  = 1'b0;
        cycles = 0;
        done   = 1'b0;
        while (!done && cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (cycles == 2) begin
                l_req   = 1'b1;
                l_addr  = 16'h0500;
                l_wdata = 32'h12345678;
                pushWrites(16'h0500, 32'h12345678);
            end
            #1;
            if (f_valid) begin
                done = 1'b1;
            end else begin
                checkOutput("blk l_ready busy", 32'(l_ready), 32'd0);
                checkOutput("blk mem_we", 32'(mem_we), 32'd0);
            end
        end
        checkOutput("blk fetch latency", 32'(cycles), 32'(BEATS + 2));
        checkOutput("blk l_ready idle", 32'(l_ready), 32'd1);
        @(posedge clk);
        #1;
        l_req  = 1'b0;
        cycles = 0;
        while (!l_done && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("blk l_done", 32'(l_done), 32'd1);

        // Reset during beat 2 of a load: bytes 0..1 land, bytes 2..3 do not.
        mem[16'h0400] = 8'h77;
        mem[16'h0401] = 8'h77;
        mem[16'h0402] = 8'h77;
        mem[16'h0403] = 8'h77;
        pushWrites(16'h0400, 32'hCAFEF00D);
        @(negedge clk);
        l_req   = 1'b1;
        l_addr  = 16'h0400;
        l_wdata = 32'hCAFEF00D;
        #1;
        checkOutput("rst l_ready", 32'(l_ready), 32'd1);
        @(posedge clk);
        #1;
        l_req = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst beat2 addr", 32'(mem_addr), 32'h0402);
        #1;
        rst_n = 1'b0;
        writeQ.delete();
        @(negedge clk);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst f_instr", f_instr, 32'd0);
        checkOutput("rst mem_wdata", 32'(mem_wdata), 32'd0);
        checkOutput("partial word",
                    32'({mem[16'h0403], mem[16'h0402], mem[16'h0401], mem[16'h0400]}),
                    32'h7777F00D);
        rst_n = 1'b1;

        // Both requesting straight out of reset: F, L, F, L.
        expOrder = '{1'b0, 1'b1, 1'b0, 1'b1};
        f_req   = 1'b1;
        f_addr  = 16'h0010;
        l_req   = 1'b1;
        l_addr  = 16'h0300;
        l_wdata = 32'h0BADF00D;
        expQ.push_back(32'h93500013);
        expQ.push_back(32'h93500013);
        pushWrites(16'h0300, 32'h0BADF00D);
        pushWrites(16'h0300, 32'h0BADF00D);
        #1;
        for (int g = 0; g < 4; g++) begin
            waits    = 0;
            gotGrant = 1'b0;
            gotL     = 1'b0;
            while (!gotGrant && waits < 40) begin
                if (f_ready || l_ready) begin
                    checkOutput("single ready", 32'(f_ready & l_ready), 32'd0);
                    gotL     = l_ready;
                    gotGrant = 1'b1;
                end else begin
                    @(negedge clk);
                    #1;
                    waits++;
                end
            end
            if (!gotGrant) checkOutput("grant timeout", 32'd1, 32'd0);
            else           checkOutput($sformatf("grant order %0d", g), 32'(gotL), 32'(expOrder[g]));
            @(posedge clk);
            #1;
            if (g == 3) begin
                f_req = 1'b0;
                l_req = 1'b0;
            end
            @(negedge clk);
            #1;
        end
        waits = 0;
        while (busy && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        checkOutput("arb drained", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("expQ empty", 32'(expQ.size()), 32'd0);
        checkOutput("writeQ empty", 32'(writeQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
